// File: rtl/fixedpointrequantizer_if.sv
// Valid/ready bus: wide scaler results in, requantized narrow words out.
interface fixedpointrequantizer_if #(
  parameter int unsigned BI = 45,
  parameter int unsigned BO = 8,
  parameter int unsigned BS = 6
);
  logic          i_valid;
  logic          i_ready;
  logic [BI-1:0] i_data;
  logic [BS-1:0] i_shift;
  logic          o_valid;
  logic          o_ready;
  logic [BO-1:0] o_data;
  logic          o_sat;

  modport master (
    output i_valid, i_data, i_shift, o_ready,
    input  i_ready, o_valid, o_data, o_sat
  );

  modport slave (
    input  i_valid, i_data, i_shift, o_ready,
    output i_ready, o_valid, o_data, o_sat
  );
endinterface

// File: rtl/fixedpointrequantizer.sv
// Requantizer: round-half-up arithmetic right shift of a wide signed result,
// then saturation to BO bits, in a two-stage valid/ready pipeline.
module fixedpointrequantizer #(
  parameter int unsigned BI = 45,
  parameter int unsigned BO = 8,
  parameter int unsigned BS = 6,
  parameter int unsigned BC = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  fixedpointrequantizer_if.slave bus,
  input  logic                   cnt_clr,
  output logic [BC-1:0]          sat_cnt
);
  localparam int unsigned BR = BI + 1;
  localparam int unsigned SW = $clog2(BI);
  localparam logic signed [BR-1:0] MAX_V = {{(BR-BO+1){1'b0}}, {(BO-1){1'b1}}};
  localparam logic signed [BR-1:0] MIN_V = ~MAX_V;

  logic                 s1_valid;
  logic signed [BR-1:0] s1_r;
  logic                 s1_en;
  logic                 s2_en;

  logic [SW-1:0]        shamt_c;
  logic signed [BR-1:0] ext_c;
  logic signed [BR-1:0] half_c;
  logic signed [BR-1:0] sum_c;
  logic signed [BR-1:0] r_c;
  logic                 sat_hi_c;
  logic                 sat_lo_c;
  logic [BO-1:0]        q_c;

  assign s2_en       = !bus.o_valid || bus.o_ready;
  assign s1_en       = !s1_valid || s2_en;
  assign bus.i_ready = s1_en;

  // Stage 1 datapath: one extra bit of headroom keeps the rounding add exact.
  always_comb begin
    shamt_c = (32'(bus.i_shift) > 32'(BI - 1)) ? SW'(BI - 1) : SW'(bus.i_shift);
    ext_c   = {bus.i_data[BI-1], bus.i_data};
    half_c  = (BR'(1) << shamt_c) >> 1;
    sum_c   = ext_c + half_c;
    r_c     = sum_c >>> shamt_c;
  end

  // Data only loads on a valid word so idle X never enters the pipeline.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else if (s1_en) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) s1_r <= r_c;
    end
  end

  always_comb begin
    sat_hi_c = (s1_r > MAX_V);
    sat_lo_c = (s1_r < MIN_V);
    q_c      = s1_r[BO-1:0];
    if (sat_hi_c) q_c = MAX_V[BO-1:0];
    if (sat_lo_c) q_c = MIN_V[BO-1:0];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_sat   <= 1'b0;
    end else if (s2_en) begin
      bus.o_valid <= s1_valid;
      if (s1_valid) begin
        bus.o_data <= q_c;
        bus.o_sat  <= sat_hi_c || sat_lo_c;
      end
    end
  end

  // Counts delivered saturated words; sticks at all-ones, clear wins.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (bus.o_valid && bus.o_ready && bus.o_sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + BC'(1);
    end
  end
endmodule
